ram_latency_model: RTL and testbench
====================================

Name: ram_latency_model

Overview:
- Word-addressed synchronous RAM with programmable access latency.
- Sits directly downstream of the CPU top block and consumes its cpu_ram_if.cpu side (memaddr, memstore, memREN, memWEN).
- Returns ramload and ramstate to the memory controller.
- Provides the cycle-accurate BUSY/ACCESS handshake that memory_control arbitrates against.

Parameters:
- LAT, 2, number of BUSY cycles before ACCESS; legal range 0..15.
- DEPTH, 16384, storage size in 32-bit words (64 KB).

Ports:
- CLK  input  1  system clock, rising-edge.
- nRST  input  1  asynchronous active-low reset.
- memaddr  input  32  byte address; must be word aligned.
- memstore  input  32  write data.
- memREN  input  1  read request.
- memWEN  input  1  write request.
- ramload  output  32  read data.
- ramstate  output  2  FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11 (ramstate_t encoding).

Behaviour:
- Reset: async, active-low. On reset, ramstate=FREE, ramload=32'h0, latency counter=0, latched request cleared.
  - Storage contents are not reset.
  - Reset asserted mid-access aborts it; no write commits.
- A request is valid when exactly one of memREN/memWEN is 1. Its identity is the tuple {memaddr, memREN, memWEN, memstore}.
- FSM states are FREE, BUSY, ACCESS and ERROR. All outputs are registered.
- FREE / ACCESS, at a rising edge:
  - No request: go to FREE.
  - Illegal request: go to ERROR.
  - Valid request: latch the tuple. If LAT>0, load counter=LAT-1 and go to BUSY. If LAT==0, perform the access at this edge and go to ACCESS.
- BUSY, at a rising edge:
  - Request deasserted: abort and go to FREE; no write.
  - Tuple differs from the latched one: re-latch, reload counter, stay in BUSY (restart).
  - Counter>0: decrement.
  - Counter==0: perform the access and go to ACCESS.
- Performing the access:
  - Read: ramload <= mem[addr[31:2]].
  - Write: mem[addr[31:2]] <= memstore, and ramload <= memstore.
- ACCESS lasts exactly one cycle. If the same request is still held at the next edge, it is treated as a new request (BUSY again); there is no implicit repeat-without-latency.
- Consequence: with LAT=L, ramstate reads BUSY for L cycles, then ACCESS for 1 cycle.
- Illegal request is any of: memREN&memWEN=1, memaddr[1:0]!=0, or memaddr[31:2]>=DEPTH.
  - ERROR is held while the illegal request persists.
  - No storage write and no ramload change while in ERROR.
  - Exit from ERROR uses the same rules as FREE.
- ramload holds its last value outside ACCESS.
- Counter width is 4 bits; no wrap, because the counter is only decremented while >0.

Test Plan:
- Reset/idle: assert nRST=0 mid-BUSY of a write to 0x40 with memstore=0xDEADBEEF, LAT=2 -> ramstate=FREE and ramload=0 immediately; a later read of 0x40 must not return 0xDEADBEEF.
- Write-then-read timing, LAT=2: WEN addr 0x100 data 0x12345678 -> BUSY, BUSY, ACCESS (3rd cycle after request edge), then drop WEN. REN 0x100 -> BUSY×2, then ACCESS with ramload=0x12345678.
- LAT=0: REN 0x8 preloaded with 0xA5A5A5A5 -> ACCESS on the first edge with ramload=0xA5A5A5A5, no BUSY cycle.
- Address change mid-BUSY, LAT=3: REN 0x10, switch to 0x20 after 1 BUSY cycle -> counter restarts; 3 more BUSY cycles, then ACCESS with data from 0x20.
- Abort: WEN 0x30 data 0x1111 held for 1 BUSY cycle, then dropped -> FREE; a subsequent read of 0x30 returns the prior contents, not 0x1111.
- Errors: REN&WEN on 0x0, or REN on 0x2, or REN on 0x10000 (DEPTH=16384) -> ERROR while held, ramload unchanged; drop request -> FREE next edge.

Source files
------------

// File: rtl/ram_latency_model_if.sv
// Bus between the CPU-side requester and the latency-modelled RAM.
// The master drives the request (address, write data, read/write enables).
// The slave (the RAM) returns read data and the FREE/BUSY/ACCESS/ERROR state.
interface ram_latency_model_if;
    logic [31:0] memaddr;
    logic [31:0] memstore;
    logic        memREN;
    logic        memWEN;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output memaddr,
        output memstore,
        output memREN,
        output memWEN,
        input  ramload,
        input  ramstate
    );

    modport slave (
        input  memaddr,
        input  memstore,
        input  memREN,
        input  memWEN,
        output ramload,
        output ramstate
    );
endinterface

// File: rtl/ram_latency_model.sv
// Word-addressed synchronous RAM with a programmable access latency.
// A valid request is held for LAT BUSY cycles and is then serviced in a single
// ACCESS cycle. Changing any part of the request while BUSY restarts the wait.
// Dropping the request while BUSY aborts it, and no write commits.
// Illegal requests park the block in ERROR until they are withdrawn.
module ram_latency_model #(
    parameter int unsigned LAT   = 2,      // BUSY cycles before ACCESS, 0..15
    parameter int unsigned DEPTH = 16384   // storage size in 32-bit words
) (
    input  logic               CLK,
    input  logic               nRST,
    ram_latency_model_if.slave bus
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_RELOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam logic [31:0] DEPTH_32  = 32'(DEPTH);

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Control state
    ramstate_t   r_state;
    ramstate_t   w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;

    // Latched request identity, used to detect a changed request while BUSY
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_ren;
    logic        r_wen;

    // Datapath
    logic [31:0] r_ramload;
    logic [31:0] r_mem [DEPTH];

    // Request decode
    logic          w_req_any;
    logic          w_illegal;
    logic          w_same;
    logic          w_latch;
    logic          w_do_access;
    logic          w_do_write;
    logic [AW-1:0] w_word;

    assign w_req_any = bus.memREN | bus.memWEN;

    // Both enables, a misaligned address, or a word beyond the array are all
    // rejected; "no request" is decided before this is looked at.
    assign w_illegal = (bus.memREN & bus.memWEN)
                     | (bus.memaddr[1:0] != 2'b00)
                     | ({2'b00, bus.memaddr[31:2]} >= DEPTH_32);

    assign w_same = (bus.memaddr  == r_addr)
                  & (bus.memstore == r_data)
                  & (bus.memREN   == r_ren)
                  & (bus.memWEN   == r_wen);

    // The access always happens on an edge where the live request equals the
    // latched one (or is being latched right now with LAT==0), so the live bus
    // values can address the array directly.
    assign w_word     = bus.memaddr[AW+1:2];
    assign w_do_write = w_do_access & bus.memWEN & nRST;

    // Next-state, counter reload/decrement and access strobe
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        w_do_access  = 1'b0;
        unique case (r_state)
            BUSY: begin
                if (!w_req_any) begin
                    w_next_state = FREE;
                end else if (w_illegal) begin
                    w_next_state = ERROR;
                end else if (!w_same) begin
                    // Any change to the request restarts the full latency
                    w_latch      = 1'b1;
                    w_next_cnt   = LAT_RELOAD;
                    w_next_state = BUSY;
                end else if (r_cnt != 4'd0) begin
                    w_next_cnt   = r_cnt - 4'd1;
                end else begin
                    w_do_access  = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            default: begin
                // FREE, ACCESS and ERROR all accept a fresh request; a request
                // still held after ACCESS is serviced again with full latency.
                if (!w_req_any) begin
                    w_next_state = FREE;
                end else if (w_illegal) begin
                    w_next_state = ERROR;
                end else begin
                    w_latch = 1'b1;
                    if (LAT == 0) begin
                        w_do_access  = 1'b1;
                        w_next_state = ACCESS;
                    end else begin
                        w_next_cnt   = LAT_RELOAD;
                        w_next_state = BUSY;
                    end
                end
            end
        endcase
    end

    // State register, latency counter and latched request
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FREE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_latch) begin
                r_addr <= bus.memaddr;
                r_data <= bus.memstore;
                r_ren  <= bus.memREN;
                r_wen  <= bus.memWEN;
            end
        end
    end

    // Read data register: loads on ACCESS only, holds otherwise; writes echo
    // the stored word back.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ramload <= 32'h0;
        end else if (w_do_access) begin
            r_ramload <= bus.memWEN ? bus.memstore : r_mem[w_word];
        end
    end

    // Storage array: never reset, and gated off while reset is asserted
    always_ff @(posedge CLK) begin
        if (w_do_write) begin
            r_mem[w_word] <= bus.memstore;
        end
    end

    assign bus.ramload  = r_ramload;
    assign bus.ramstate = r_state;

endmodule

// File: tb/tb_ram_latency_model.sv
// Self-checking bench for ram_latency_model.
// Three instances (LAT = 0, 2, 3) share one stimulus stream. A request-level
// reference model per instance predicts ramstate/ramload every cycle, and
// directed scenarios add literal expectations on top.
`timescale 1ns/1ps
module tb_ram_latency_model;

    localparam int DEPTH = 16384;
    localparam logic [1:0] S_FREE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_ACC  = 2'b10;
    localparam logic [1:0] S_ERR  = 2'b11;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_data = 32'h0;
    logic        d_ren  = 1'b0;
    logic        d_wen  = 1'b0;

    always #5 CLK = ~CLK;

    ram_latency_model_if bus0 ();
    ram_latency_model_if bus2 ();
    ram_latency_model_if bus3 ();

    assign bus0.memaddr = d_addr;  assign bus0.memstore = d_data;
    assign bus0.memREN  = d_ren;   assign bus0.memWEN   = d_wen;
    assign bus2.memaddr = d_addr;  assign bus2.memstore = d_data;
    assign bus2.memREN  = d_ren;   assign bus2.memWEN   = d_wen;
    assign bus3.memaddr = d_addr;  assign bus3.memstore = d_data;
    assign bus3.memREN  = d_ren;   assign bus3.memWEN   = d_wen;

    ram_latency_model #(.LAT(0), .DEPTH(DEPTH)) dut0 (.CLK(CLK), .nRST(nRST), .bus(bus0));
    ram_latency_model #(.LAT(2), .DEPTH(DEPTH)) dut2 (.CLK(CLK), .nRST(nRST), .bus(bus2));
    ram_latency_model #(.LAT(3), .DEPTH(DEPTH)) dut3 (.CLK(CLK), .nRST(nRST), .bus(bus3));

    // Observed outputs, index 0/1/2 = LAT 0/2/3
    logic [1:0]  o_st [3];
    logic [31:0] o_ld [3];
    assign o_st[0] = bus0.ramstate;  assign o_ld[0] = bus0.ramload;
    assign o_st[1] = bus2.ramstate;  assign o_ld[1] = bus2.ramload;
    assign o_st[2] = bus3.ramstate;  assign o_ld[2] = bus3.ramload;

    int lat_of [3] = '{0, 2, 3};

    // Reference model: a request "ages" one step per edge while held unchanged;
    // it is serviced on the edge where its age reaches LAT.
    logic [1:0]  m_state  [3];
    logic [31:0] m_load   [3];
    bit          m_lknown [3];
    bit          m_pend   [3];
    int          m_age    [3];
    logic [65:0] m_tuple  [3];
    logic [31:0] m_mem    [3][DEPTH];
    bit          m_known  [3][DEPTH];
    bit          m_init = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic model_edge(input int k);
        logic [65:0] cur;
        bit none, illegal;
        int w;
        cur     = {d_addr, d_ren, d_wen, d_data};
        none    = !d_ren && !d_wen;
        illegal = (d_ren && d_wen) || (d_addr[1:0] != 2'b00) || (d_addr[31:2] >= DEPTH);
        if (none) begin
            m_pend[k]  = 1'b0;
            m_state[k] = S_FREE;
        end else if (illegal) begin
            m_pend[k]  = 1'b0;
            m_state[k] = S_ERR;
        end else begin
            if (m_pend[k] && cur == m_tuple[k]) begin
                m_age[k] = m_age[k] + 1;
            end else begin
                m_tuple[k] = cur;
                m_age[k]   = 0;
                m_pend[k]  = 1'b1;
            end
            if (m_age[k] == lat_of[k]) begin
                m_pend[k]  = 1'b0;
                m_state[k] = S_ACC;
                w = int'(d_addr[31:2]);
                if (d_wen) begin
                    m_mem[k][w]   = d_data;
                    m_known[k][w] = 1'b1;
                    m_load[k]     = d_data;
                    m_lknown[k]   = 1'b1;
                end else begin
                    m_load[k]   = m_mem[k][w];
                    m_lknown[k] = m_known[k][w];
                end
            end else begin
                m_state[k] = S_BUSY;
            end
        end
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < 3; k++) begin
                m_state[k]  = S_FREE;
                m_load[k]   = 32'h0;
                m_lknown[k] = 1'b1;
                m_pend[k]   = 1'b0;
                m_age[k]    = 0;
            end
            m_init = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) model_edge(k);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (m_init) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_state_L%0d", lat_of[k]), {30'd0, o_st[k]}, {30'd0, m_state[k]});
                if (m_lknown[k])
                    check($sformatf("model_load_L%0d", lat_of[k]), o_ld[k], m_load[k]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dd);
        d_ren  = r;
        d_wen  = w;
        d_addr = a;
        d_data = dd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic exp_st(input int k, input string name, input logic [1:0] s);
        check(name, {30'd0, o_st[k]}, {30'd0, s});
    endtask

    task automatic exp_ld(input int k, input string name, input logic [31:0] v);
        check(name, o_ld[k], v);
    endtask

    // Write a word through every instance (LAT 3 needs four held edges)
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        drive(1'b0, 1'b1, a, v);
        tick(4);
        idle();
        tick(1);
    endtask

    logic [31:0] err_addr [3] = '{32'h0, 32'h2, 32'h10000};

    initial begin
        int p;
        logic [31:0] a;
        logic r, w;

        // Reset and idle
        idle();
        nRST = 1'b0;
        tick(3);
        nRST = 1'b1;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            exp_st(k, "reset_state", S_FREE);
            exp_ld(k, "reset_load", 32'h0);
        end

        // Write then read, LAT=2
        drive(1'b0, 1'b1, 32'h100, 32'h12345678);
        tick(1); exp_st(1, "wr_busy1", S_BUSY);
        tick(1); exp_st(1, "wr_busy2", S_BUSY);
        tick(1); exp_st(1, "wr_access", S_ACC); exp_ld(1, "wr_echo", 32'h12345678);
        idle();
        tick(1); exp_st(1, "wr_free", S_FREE);
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        tick(1); exp_st(1, "rd_busy1", S_BUSY);
        tick(1); exp_st(1, "rd_busy2", S_BUSY);
        tick(1); exp_st(1, "rd_access", S_ACC); exp_ld(1, "rd_data", 32'h12345678);
        idle();
        tick(1);

        // LAT=0 read has no BUSY cycle
        preload(32'h8, 32'hA5A5A5A5);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        tick(1); exp_st(0, "lat0_access", S_ACC); exp_ld(0, "lat0_data", 32'hA5A5A5A5);
        idle();
        tick(1);

        // Address change mid-BUSY restarts the wait, LAT=3
        preload(32'h10, 32'h10101010);
        preload(32'h20, 32'h20202020);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        tick(1); exp_st(2, "chg_busy0", S_BUSY);
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        tick(1); exp_st(2, "chg_busy1", S_BUSY);
        tick(1); exp_st(2, "chg_busy2", S_BUSY);
        tick(1); exp_st(2, "chg_busy3", S_BUSY);
        tick(1); exp_st(2, "chg_access", S_ACC); exp_ld(2, "chg_data", 32'h20202020);
        idle();
        tick(1);

        // Aborted write leaves prior contents, LAT=2
        preload(32'h30, 32'h77777777);
        drive(1'b0, 1'b1, 32'h30, 32'h1111);
        tick(1); exp_st(1, "abort_busy", S_BUSY);
        idle();
        tick(1); exp_st(1, "abort_free", S_FREE);
        drive(1'b1, 1'b0, 32'h30, 32'h0);
        tick(3); exp_st(1, "abort_rd_access", S_ACC); exp_ld(1, "abort_rd_data", 32'h77777777);
        idle();
        tick(1);

        // Illegal requests: both enables, misaligned, out of range
        for (int e = 0; e < 3; e++) begin
            drive(1'b1, (e == 0), err_addr[e], 32'hCAFE0000);
            tick(1); exp_st(1, $sformatf("err%0d_enter", e), S_ERR);
            tick(1); exp_st(1, $sformatf("err%0d_hold", e), S_ERR);
            exp_ld(1, $sformatf("err%0d_load", e), 32'h77777777);
            idle();
            tick(1); exp_st(1, $sformatf("err%0d_exit", e), S_FREE);
        end

        // Reset in the middle of a BUSY write
        preload(32'h40, 32'h0BADF00D);
        drive(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        tick(1); exp_st(1, "rst_pre_busy", S_BUSY);
        nRST = 1'b0;
        #1;
        exp_st(1, "rst_async_state", S_FREE);
        exp_ld(1, "rst_async_load", 32'h0);
        tick(2);
        idle();
        nRST = 1'b1;
        tick(1);
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        tick(3); exp_st(1, "rst_rd_access", S_ACC); exp_ld(1, "rst_rd_data", 32'h0BADF00D);
        idle();
        tick(1);

        // Randomised traffic, checked against the model every cycle
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 30) begin
                p = int'($urandom_range(0, 19));
                a = 32'($urandom_range(0, 63)) << 2;
                if (p == 0) a = a | 32'h1;
                if (p == 1) a = 32'($urandom_range(DEPTH, DEPTH + 100)) << 2;
                if (p == 2) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                r = 1'($urandom_range(0, 1));
                w = ~r;
                if (p == 3) begin r = 1'b1; w = 1'b1; end
                if (p == 4 || p == 5) begin r = 1'b0; w = 1'b0; end
                drive(r, w, a, $urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                nRST = 1'b0;
                tick(1);
                nRST = 1'b1;
            end
            tick(1);
        end

        idle();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
